// File: rtl/instr_fetch_unit_if.sv
// Byte-intake and decoded-packet bundle between fifo_rx, the fetch unit and the controller.
// master = fetch unit side (pops bytes, presents packets); slave = surrounding fifo/controller side.
interface instr_fetch_unit_if #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int ADDRESS_SIZE     = 9,
  parameter int OPCODE_WIDTH     = 3
);
  logic                        rx_empty;
  logic [FIFO_DATA_WIDTH-1:0]  rx_data;
  logic                        rx_re;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [BUFFER_WORD_SIZE-1:0] pkt_instr;
  logic [OPCODE_WIDTH-1:0]     pkt_opcode;
  logic [ADDRESS_SIZE-1:0]     pkt_addr;
  logic [BUFFER_WORD_SIZE-1:0] pkt_data;
  logic                        pkt_illegal;
  logic                        pkt_addr_oob;
  logic                        halted;
  logic [BUFFER_WORD_SIZE-1:0] instr_count;

  modport master (
    input  rx_empty, rx_data, pkt_ready,
    output rx_re, pkt_valid, pkt_instr, pkt_opcode, pkt_addr, pkt_data,
           pkt_illegal, pkt_addr_oob, halted, instr_count
  );

  modport slave (
    output rx_empty, rx_data, pkt_ready,
    input  rx_re, pkt_valid, pkt_instr, pkt_opcode, pkt_addr, pkt_data,
           pkt_illegal, pkt_addr_oob, halted, instr_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Assembles little-endian instruction/address/data words from fifo_rx into one decoded packet.
// pkt_valid rises the cycle after the last byte pop; intake stalls (no prefetch) until pkt_ready.
module instr_fetch_unit #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int ADDRESS_SIZE     = 9,
  parameter int OPCODE_WIDTH     = 3
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    I_LO    = 3'd0,
    I_HI    = 3'd1,
    A_LO    = 3'd2,
    A_HI    = 3'd3,
    D_LO    = 3'd4,
    D_HI    = 3'd5,
    PRESENT = 3'd6,
    HALT    = 3'd7
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE      = '0;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT       = OPCODE_WIDTH'(4);
  localparam int                      ADDR_FLAG_BIT = 4;

  state_t state_q;
  state_t state_d;

  logic [FIFO_DATA_WIDTH-1:0]  lo_q;
  logic [BUFFER_WORD_SIZE-1:0] instr_q;
  logic [ADDRESS_SIZE-1:0]     addr_q;
  logic [BUFFER_WORD_SIZE-1:0] data_q;
  logic                        illegal_q;
  logic                        addr_oob_q;
  logic [BUFFER_WORD_SIZE-1:0] count_q;

  logic                        pop;
  logic                        accept;
  logic [BUFFER_WORD_SIZE-1:0] word;
  logic [OPCODE_WIDTH-1:0]     lo_opcode;

  // Every word is completed by the byte currently at the FIFO head.
  assign word      = {bus.rx_data, lo_q};
  assign lo_opcode = lo_q[OPCODE_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= I_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      I_LO, I_HI, A_LO, A_HI, D_LO, D_HI: pop = ~bus.rx_empty;
      PRESENT:                            accept = bus.pkt_ready;
      default:                            ;
    endcase

    case (state_q)
      I_LO: if (pop) state_d = I_HI;
      I_HI: begin
        if (pop) begin
          if (lo_opcode == OP_STORE) begin
            state_d = lo_q[ADDR_FLAG_BIT] ? A_LO : D_LO;
          end else begin
            state_d = PRESENT;
          end
        end
      end
      A_LO: if (pop) state_d = A_HI;
      A_HI: if (pop) state_d = D_LO;
      D_LO: if (pop) state_d = D_HI;
      D_HI: if (pop) state_d = PRESENT;
      PRESENT: begin
        if (accept) begin
          state_d = (instr_q[OPCODE_WIDTH-1:0] == OP_HALT) ? HALT : I_LO;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = I_LO;
    endcase
  end

  // Operand fields are defaulted when the instruction word completes, then overridden by operand words.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q       <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      illegal_q  <= 1'b0;
      addr_oob_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (pop) begin
        case (state_q)
          I_LO, A_LO, D_LO: lo_q <= bus.rx_data;
          I_HI: begin
            instr_q    <= word;
            addr_q     <= word[BUFFER_WORD_SIZE-1 -: ADDRESS_SIZE];
            data_q     <= '0;
            addr_oob_q <= 1'b0;
            illegal_q  <= (lo_opcode > OP_HALT);
          end
          A_HI: begin
            addr_q     <= word[ADDRESS_SIZE-1:0];
            addr_oob_q <= |word[BUFFER_WORD_SIZE-1:ADDRESS_SIZE];
          end
          D_HI:    data_q <= word;
          default: ;
        endcase
      end
      if (accept) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.rx_re        = pop;
  assign bus.pkt_valid    = (state_q == PRESENT);
  assign bus.pkt_instr    = instr_q;
  assign bus.pkt_opcode   = instr_q[OPCODE_WIDTH-1:0];
  assign bus.pkt_addr     = addr_q;
  assign bus.pkt_data     = data_q;
  assign bus.pkt_illegal  = illegal_q;
  assign bus.pkt_addr_oob = addr_oob_q;
  assign bus.halted       = (state_q == HALT);
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte FIFO stand-in, length-based packet model, per-cycle compare.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [8:0]  addr;
    logic [15:0] data;
    logic        illegal;
    logic        oob;
  } pkt_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] pend[$];
  pkt_t       exp_q[$];
  logic       parse_halted = 1'b0;
  int         gap_len      = 0;
  int         gap_left     = 0;
  int         pops_total   = 0;
  logic [15:0] model_count = '0;
  logic       model_halted = 1'b0;
  logic       prev_valid   = 1'b0;
  logic       prev_pop     = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packet boundaries come purely from the opcode/flag length rules.
  task automatic model_push(input logic [7:0] b);
    logic [15:0] instr;
    logic [15:0] aw;
    logic [2:0]  op;
    int          need;
    pkt_t        p;
    if (parse_halted) return;
    pend.push_back(b);
    if (pend.size() < 2) return;
    instr = {pend[1], pend[0]};
    op    = instr[2:0];
    need  = (op == 3'd0) ? (instr[4] ? 6 : 4) : 2;
    if (pend.size() < need) return;
    p.instr   = instr;
    p.addr    = instr[15:7];
    p.data    = 16'h0000;
    p.oob     = 1'b0;
    p.illegal = (op > 3'd4);
    if (op == 3'd0 && instr[4]) begin
      aw     = {pend[3], pend[2]};
      p.addr = aw[8:0];
      p.oob  = |aw[15:9];
      p.data = {pend[5], pend[4]};
    end else if (op == 3'd0) begin
      p.data = {pend[3], pend[2]};
    end
    exp_q.push_back(p);
    if (op == 3'd4) parse_halted = 1'b1;
    pend.delete();
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    parse_halted = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    model_push(b);
  endtask

  task automatic wait_valid(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.pkt_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    for (int i = 0; i < budget && pops_total < target; i++) @(negedge clk);
    check(name, pops_total, target);
  endtask

  // FIFO stand-in: first-word-fall-through head, optional empty gap after each pop.
  initial begin
    logic pop_now;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      pop_now = bus.rx_re && !bus.rx_empty && !rst;
      @(posedge clk);
      if (pop_now) begin
        void'(fifo_q.pop_front());
        pops_total++;
        gap_left = gap_len;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      #1;
      bus.rx_empty = (fifo_q.size() == 0) || (gap_left > 0);
      bus.rx_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Per-cycle compare against the model.
  initial begin
    pkt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_count  = '0;
        model_halted = 1'b0;
        prev_valid   = 1'b0;
        prev_pop     = 1'b0;
      end else begin
        check("instr_count", bus.instr_count, model_count);
        check("halted", bus.halted, model_halted);
        check("rx_re_rule", bus.rx_re, !bus.rx_empty && !bus.pkt_valid && !bus.halted);
        if (bus.halted) check("valid_in_halt", bus.pkt_valid, 0);
        if (bus.pkt_valid && !prev_valid) check("valid_latency", prev_pop, 1);
        if (bus.pkt_valid) begin
          check("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("pkt_fields",
                  {bus.pkt_instr, bus.pkt_opcode, bus.pkt_addr, bus.pkt_data, bus.pkt_illegal, bus.pkt_addr_oob},
                  {e.instr, e.instr[2:0], e.addr, e.data, e.illegal, e.oob});
            if (bus.pkt_ready) begin
              if (e.instr[2:0] == 3'd4) model_halted = 1'b1;
              model_count = model_count + 16'd1;
              void'(exp_q.pop_front());
            end
          end
        end
        prev_valid = bus.pkt_valid;
        prev_pop   = bus.rx_re && !bus.rx_empty;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst           = 1'b1;
    bus.pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", bus.pkt_valid, 0);
    check("rst_rx_re", bus.rx_re, 0);
    check("rst_fields", {bus.pkt_instr, bus.pkt_addr, bus.pkt_data, bus.pkt_illegal, bus.pkt_addr_oob}, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_count", bus.instr_count, 0);

    // RUN word
    @(posedge clk); #1 bus.pkt_ready = 1'b1;
    base = pops_total;
    push(8'hBA); push(8'hD2);
    wait_valid(20, "run_valid");
    check("run_instr", bus.pkt_instr, 16'hD2BA);
    check("run_opcode", bus.pkt_opcode, 2);
    check("run_addr", bus.pkt_addr, 9'h1A5);
    check("run_data", bus.pkt_data, 0);
    check("run_illegal", bus.pkt_illegal, 0);
    check("run_pops", pops_total - base, 2);
    @(negedge clk);
    check("run_count", bus.instr_count, 1);
    check("run_valid_drop", bus.pkt_valid, 0);

    // STORE with explicit address, in range then out of range
    push(8'h10); push(8'h00); push(8'h34); push(8'h01); push(8'hEF); push(8'hBE);
    wait_valid(30, "st_valid");
    check("st_opcode", bus.pkt_opcode, 0);
    check("st_addr", bus.pkt_addr, 9'h134);
    check("st_data", bus.pkt_data, 16'hBEEF);
    check("st_oob", bus.pkt_addr_oob, 0);
    push(8'h10); push(8'h00); push(8'h34); push(8'h81); push(8'hEF); push(8'hBE);
    wait_valid(30, "st_oob_valid");
    check("st2_addr", bus.pkt_addr, 9'h134);
    check("st2_oob", bus.pkt_addr_oob, 1);

    // STORE with implicit address and 2-cycle gaps between bytes
    gap_len = 2;
    push(8'h80); push(8'h00); push(8'h55); push(8'hAA);
    wait_valid(40, "imp_valid");
    gap_len = 0;
    check("imp_addr", bus.pkt_addr, 9'h001);
    check("imp_data", bus.pkt_data, 16'hAA55);
    check("imp_oob", bus.pkt_addr_oob, 0);

    // Backpressure: RUN held 3 cycles with more bytes waiting
    @(posedge clk); #1 bus.pkt_ready = 1'b0;
    push(8'hBA); push(8'hD2); push(8'h02); push(8'h00);
    wait_valid(20, "bp_valid");
    check("bp_instr", bus.pkt_instr, 16'hD2BA);
    check("bp_count_before", bus.instr_count, 4);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_valid", bus.pkt_valid, 1);
      check("bp_hold_instr", bus.pkt_instr, 16'hD2BA);
      check("bp_no_pop", bus.rx_re, 0);
      check("bp_count_hold", bus.instr_count, 4);
    end
    @(posedge clk); #1 bus.pkt_ready = 1'b1;
    @(negedge clk);
    check("bp_4th_valid", bus.pkt_valid, 1);
    @(negedge clk);
    check("bp_count_after", bus.instr_count, 5);
    wait_valid(20, "run2_valid");
    check("run2_instr", bus.pkt_instr, 16'h0002);
    check("run2_addr", bus.pkt_addr, 0);

    // Illegal opcode, then HALT with trailing bytes that must stay in the FIFO
    push(8'h06); push(8'h00);
    wait_valid(20, "ill_valid");
    check("ill_flag", bus.pkt_illegal, 1);
    check("ill_opcode", bus.pkt_opcode, 6);
    push(8'h04); push(8'h00); push(8'h01); push(8'h00);
    wait_valid(20, "halt_valid");
    check("halt_opcode", bus.pkt_opcode, 4);
    repeat (10) @(negedge clk);
    check("halt_flag", bus.halted, 1);
    check("halt_fifo_left", fifo_q.size(), 2);
    check("halt_count", bus.instr_count, 8);

    // Leave HALT, then reset in the middle of a STORE
    @(posedge clk); #1 rst = 1'b1;
    fifo_q.delete();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    base = pops_total;
    push(8'h10); push(8'h00); push(8'h34);
    wait_pops(base + 3, 30, "mid_pops");
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", bus.pkt_valid, 0);
    check("mid_rst_fields", {bus.pkt_instr, bus.pkt_addr, bus.pkt_data, bus.pkt_illegal, bus.pkt_addr_oob}, 0);
    check("mid_rst_count", bus.instr_count, 0);
    check("mid_rst_halted", bus.halted, 0);
    push(8'h02); push(8'h00);
    wait_valid(20, "post_rst_valid");
    check("post_rst_instr", bus.pkt_instr, 16'h0002);
    check("post_rst_opcode", bus.pkt_opcode, 2);
    check("post_rst_addr", bus.pkt_addr, 0);
    @(negedge clk);
    check("post_rst_count", bus.instr_count, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
